// File: rtl/packet_snap_cutter_if.sv
// AXI4-Stream bundle used on both sides of packet_snap_cutter.
//   tdata  : payload, C_AXIS_DATA_WIDTH bits
//   tkeep  : byte enables, one per payload byte
//   tuser  : metadata (length in the low bits, one-hot source port above)
//   tvalid : beat valid
//   tready : beat accepted by the sink
//   tlast  : final beat of a packet
// master drives the stream; slave receives it and drives tready.
interface packet_snap_cutter_if #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
);
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic                           tvalid;
    logic                           tready;
    logic                           tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/packet_snap_cutter.sv
// Truncates AXI4-Stream packets to a per-source-port snap length (bytes).
// The final kept beat gets a masked tkeep and a forced tlast, the tuser
// length field of the first beat is rewritten, and the remaining input
// beats are swallowed without backpressure.
// Ports:
//   axi_aclk, axi_reset : clock, asynchronous active-high reset
//   cut_en              : global truncation enable (sampled at first beat)
//   snap_len            : NUM_PORTS x LEN_WIDTH snap lengths, 0 = no cut
//   s_axis              : input stream (slave modport)
//   m_axis              : output stream (master modport), one register stage
//   trunc_count         : wrapping count of truncated packets
module packet_snap_cutter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 8,
    parameter int SRC_PORT_POS       = 16,
    parameter int LEN_WIDTH          = 16
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,
    input  logic                           cut_en,
    input  logic [NUM_PORTS*LEN_WIDTH-1:0] snap_len,
    packet_snap_cutter_if.slave            s_axis,
    packet_snap_cutter_if.master           m_axis,
    output logic [31:0]                    trunc_count
);
    localparam int B     = C_AXIS_DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(B);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {SOP, PASS, DROP} state_t;

    state_t                         state;
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata_q;
    logic [B-1:0]                   tkeep_q;
    logic [C_AXIS_TUSER_WIDTH-1:0]  tuser_q;
    logic                           tvalid_q;
    logic                           tlast_q;
    logic                           trunc_q;
    logic [LEN_WIDTH-1:0]           k_last_q;
    logic [LEN_WIDTH-1:0]           beat_k_q;
    logic [SHIFT-1:0]               rem_q;
    logic [31:0]                    count_q;

    // First-beat configuration decode, only meaningful in SOP.
    logic [PW-1:0]        port_idx;
    logic                 found;
    logic [LEN_WIDTH-1:0] snap_sel;
    logic [LEN_WIDTH-1:0] orig_len;
    logic [LEN_WIDTH-1:0] len_sel;
    logic [LEN_WIDTH-1:0] k_last;
    logic [SHIFT-1:0]     rem_now;
    logic                 trunc_now;
    logic                 in_ready;
    logic                 hs;

    always_comb begin
        port_idx = '0;
        found    = 1'b0;
        // Lowest set bit of the one-hot field wins; no bit set selects port 0.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (s_axis.tuser[SRC_PORT_POS + i] && !found) begin
                port_idx = PW'(i);
                found    = 1'b1;
            end
        end
    end

    assign snap_sel  = snap_len[port_idx*LEN_WIDTH +: LEN_WIDTH];
    assign orig_len  = s_axis.tuser[LEN_WIDTH-1:0];
    assign trunc_now = cut_en && (snap_sel != '0) && (snap_sel < orig_len);
    assign len_sel   = trunc_now ? snap_sel : orig_len;
    assign k_last    = (len_sel - LEN_WIDTH'(1)) >> SHIFT;
    assign rem_now   = len_sel[SHIFT-1:0];

    // DROP never stalls the source; otherwise accept only when the output
    // register is free or being drained this cycle.
    assign in_ready = (state == DROP) || !tvalid_q || m_axis.tready;
    assign hs       = s_axis.tvalid && in_ready;

    function automatic logic [B-1:0] tail_mask(input logic [SHIFT-1:0] r);
        if (r == '0)
            return '1;
        return (B'(1) << r) - B'(1);
    endfunction

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state    <= SOP;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            trunc_q  <= 1'b0;
            k_last_q <= '0;
            beat_k_q <= '0;
            rem_q    <= '0;
            count_q  <= '0;
        end else begin
            if (m_axis.tready)
                tvalid_q <= 1'b0;
            case (state)
                SOP: begin
                    if (hs) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= s_axis.tdata;
                        tkeep_q  <= s_axis.tkeep;
                        tuser_q  <= {s_axis.tuser[C_AXIS_TUSER_WIDTH-1:LEN_WIDTH], len_sel};
                        tlast_q  <= s_axis.tlast;
                        trunc_q  <= trunc_now;
                        k_last_q <= k_last;
                        rem_q    <= rem_now;
                        beat_k_q <= LEN_WIDTH'(1);
                        if (trunc_now)
                            count_q <= count_q + 32'd1;
                        if (trunc_now && k_last == '0) begin
                            tlast_q <= 1'b1;
                            tkeep_q <= s_axis.tkeep & tail_mask(rem_now);
                        end
                        if (s_axis.tlast)
                            state <= SOP;
                        else if (trunc_now && k_last == '0)
                            state <= DROP;
                        else
                            state <= PASS;
                    end
                end
                PASS: begin
                    if (hs) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= s_axis.tdata;
                        tkeep_q  <= s_axis.tkeep;
                        tuser_q  <= s_axis.tuser;
                        tlast_q  <= s_axis.tlast;
                        beat_k_q <= beat_k_q + LEN_WIDTH'(1);
                        if (trunc_q && beat_k_q == k_last_q) begin
                            tlast_q <= 1'b1;
                            tkeep_q <= s_axis.tkeep & tail_mask(rem_q);
                            state   <= s_axis.tlast ? SOP : DROP;
                        end else if (s_axis.tlast) begin
                            state <= SOP;
                        end
                    end
                end
                DROP: begin
                    if (hs && s_axis.tlast)
                        state <= SOP;
                end
                default: state <= SOP;
            endcase
        end
    end

    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign trunc_count   = count_q;
endmodule

// File: tb/tb_packet_snap_cutter.sv
// Directed bench for packet_snap_cutter (256-bit data, 128-bit tuser).
// Inputs change 1 time unit after the rising edge; the monitor captures
// output handshakes on the falling edge.
module tb_packet_snap_cutter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cut_en = 1'b0;
    logic [127:0] snap_len = '0;
    logic [31:0]  trunc_count;
    logic         bp_en = 1'b0;
    int           bp_ph = 0;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t        outq[$];
    logic [255:0] in_d[0:15];
    logic [31:0]  in_k[0:15];
    logic [127:0] in_u[0:15];
    int           in_n;

    packet_snap_cutter_if #(.C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128)) s_if ();
    packet_snap_cutter_if #(.C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128)) m_if ();

    packet_snap_cutter #(
        .C_AXIS_DATA_WIDTH(256),
        .C_AXIS_TUSER_WIDTH(128),
        .NUM_PORTS(8),
        .SRC_PORT_POS(16),
        .LEN_WIDTH(16)
    ) dut (
        .axi_aclk(clk),
        .axi_reset(rst),
        .cut_en(cut_en),
        .snap_len(snap_len),
        .s_axis(s_if),
        .m_axis(m_if),
        .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    // Sink ready: steady 1, or the repeating 1,0,0,1 pattern when bp_en.
    initial m_if.tready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            m_if.tready = (bp_ph == 0) || (bp_ph == 3);
            bp_ph = (bp_ph + 1) % 4;
        end else begin
            m_if.tready = 1'b1;
            bp_ph = 0;
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (!rst && m_if.tvalid && m_if.tready) begin
            b.d = m_if.tdata;
            b.k = m_if.tkeep;
            b.u = m_if.tuser;
            b.l = m_if.tlast;
            outq.push_back(b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds packet beats: payload tagged by id/beat, first-beat tuser
    // carries the one-hot port and byte length, later beats a marker.
    task automatic prep_pkt(input int id, input int nbytes, input int port);
        logic [7:0] a;
        logic [7:0] bi;
        in_n = (nbytes + 31) / 32;
        a = 8'(id);
        for (int i = 0; i < in_n; i++) begin
            bi = 8'(i);
            in_d[i] = {8{a, bi, 16'hA55A}};
            if ((i + 1) * 32 <= nbytes)
                in_k[i] = '1;
            else
                in_k[i] = (32'h1 << (nbytes - i * 32)) - 32'h1;
            if (i == 0) begin
                in_u[i] = '0;
                in_u[i][127:96] = 32'h5A5A0000 + 32'(id);
                in_u[i][16 + port] = 1'b1;
                in_u[i][15:0] = 16'(nbytes);
            end else begin
                in_u[i] = {96'h0, 32'hC0DE0000 + 32'(i)};
            end
        end
    endtask

    task automatic send_beat(input int i, output logic first_try);
        logic acc;
        s_if.tdata  = in_d[i];
        s_if.tkeep  = in_k[i];
        s_if.tuser  = in_u[i];
        s_if.tlast  = (i == in_n - 1);
        s_if.tvalid = 1'b1;
        first_try = 1'b0;
        acc = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_if.tready) begin
                first_try = (n == 0);
                acc = 1'b1;
                break;
            end
        end
        if (!acc)
            chk("accept_timeout", 256'(acc), 256'(1));
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    // Beats at index >= drop_from must be taken without waiting.
    task automatic send_pkt(input string tag, input int drop_from, input int drain);
        logic ft;
        outq.delete();
        for (int i = 0; i < in_n; i++) begin
            send_beat(i, ft);
            if (i >= drop_from)
                chk({tag, ".drop_ready"}, 256'(ft), 256'(1));
        end
        repeat (drain) @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] ek,
                            input logic el, input logic [15:0] elen);
        logic [127:0] eu;
        if (idx >= outq.size()) begin
            chk({tag, ".present"}, 256'(0), 256'(1));
            return;
        end
        eu = in_u[idx];
        if (idx == 0)
            eu[15:0] = elen;
        chk({tag, ".data"}, outq[idx].d, in_d[idx]);
        chk({tag, ".keep"}, 256'(outq[idx].k), 256'(ek));
        chk({tag, ".last"}, 256'(outq[idx].l), 256'(el));
        chk({tag, ".user"}, 256'(outq[idx].u), 256'(eu));
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.tvalid", 256'(m_if.tvalid), 256'(0));
        chk("rst.tdata", m_if.tdata, 256'(0));
        chk("rst.tkeep", 256'(m_if.tkeep), 256'(0));
        chk("rst.tuser", 256'(m_if.tuser), 256'(0));
        chk("rst.tlast", 256'(m_if.tlast), 256'(0));
        chk("rst.count", 256'(trunc_count), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic truncation: 100 bytes, snap 64
        cut_en = 1'b1;
        snap_len[0 +: 16] = 16'd64;
        prep_pkt(1, 100, 0);
        send_pkt("t1", 2, 4);
        chk("t1.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("t1.b0", 0, 32'hFFFFFFFF, 1'b0, 16'd64);
        chk_beat("t1.b1", 1, 32'hFFFFFFFF, 1'b1, 16'd64);
        chk("t1.count", 256'(trunc_count), 256'(1));

        // Partial last kept beat: snap 70
        snap_len[0 +: 16] = 16'd70;
        prep_pkt(2, 100, 0);
        send_pkt("t2", 3, 4);
        chk("t2.nbeats", 256'(outq.size()), 256'(3));
        chk_beat("t2.b1", 1, 32'hFFFFFFFF, 1'b0, 16'd70);
        chk_beat("t2.b2", 2, 32'h0000003F, 1'b1, 16'd70);
        chk("t2.len", 256'(outq[0].u[15:0]), 256'(16'd70));
        chk("t2.count", 256'(trunc_count), 256'(2));

        // Port 2 snap 40, port 0 unlimited, 60-byte packet
        snap_len[0 +: 16]  = 16'd0;
        snap_len[32 +: 16] = 16'd40;
        prep_pkt(3, 60, 2);
        send_pkt("t3a", 2, 4);
        chk("t3a.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("t3a.b0", 0, 32'hFFFFFFFF, 1'b0, 16'd40);
        chk_beat("t3a.b1", 1, 32'h000000FF, 1'b1, 16'd40);
        chk("t3a.count", 256'(trunc_count), 256'(3));

        prep_pkt(4, 60, 0);
        send_pkt("t3b", 2, 4);
        chk("t3b.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("t3b.b0", 0, 32'hFFFFFFFF, 1'b0, 16'd60);
        chk_beat("t3b.b1", 1, 32'h0FFFFFFF, 1'b1, 16'd60);
        chk("t3b.count", 256'(trunc_count), 256'(3));

        cut_en = 1'b0;
        prep_pkt(5, 60, 2);
        send_pkt("t3c", 2, 4);
        chk("t3c.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("t3c.b1", 1, 32'h0FFFFFFF, 1'b1, 16'd60);
        chk("t3c.len", 256'(outq[0].u[15:0]), 256'(16'd60));
        chk("t3c.count", 256'(trunc_count), 256'(3));

        // Single-beat truncated packet: 20 bytes cut to 10
        cut_en = 1'b1;
        snap_len[0 +: 16] = 16'd10;
        prep_pkt(6, 20, 0);
        send_pkt("t5", 1, 4);
        chk("t5.nbeats", 256'(outq.size()), 256'(1));
        chk_beat("t5.b0", 0, 32'h000003FF, 1'b1, 16'd10);
        chk("t5.count", 256'(trunc_count), 256'(4));

        // Backpressure: 10 beats, snap 96, ready pattern 1,0,0,1
        snap_len[0 +: 16] = 16'd96;
        prep_pkt(7, 320, 0);
        bp_en = 1'b1;
        send_pkt("t4", 3, 8);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4.nbeats", 256'(outq.size()), 256'(3));
        chk_beat("t4.b0", 0, 32'hFFFFFFFF, 1'b0, 16'd96);
        chk_beat("t4.b1", 1, 32'hFFFFFFFF, 1'b0, 16'd96);
        chk_beat("t4.b2", 2, 32'hFFFFFFFF, 1'b1, 16'd96);
        chk("t4.count", 256'(trunc_count), 256'(5));

        // Reset during beat 2 of a truncated packet
        snap_len[0 +: 16] = 16'd64;
        prep_pkt(8, 100, 0);
        begin
            logic ft;
            send_beat(0, ft);
        end
        s_if.tdata  = in_d[1];
        s_if.tkeep  = in_k[1];
        s_if.tuser  = in_u[1];
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("r1.tvalid", 256'(m_if.tvalid), 256'(0));
        chk("r1.tdata", m_if.tdata, 256'(0));
        chk("r1.count", 256'(trunc_count), 256'(0));
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        prep_pkt(9, 64, 0);
        send_pkt("r2", 2, 4);
        chk("r2.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("r2.b0", 0, 32'hFFFFFFFF, 1'b0, 16'd64);
        chk_beat("r2.b1", 1, 32'hFFFFFFFF, 1'b1, 16'd64);
        chk("r2.count", 256'(trunc_count), 256'(0));

        // Counter wrap from all-ones
        @(posedge clk);
        force dut.count_q = 32'hFFFFFFFF;
        @(posedge clk);
        #1 release dut.count_q;
        prep_pkt(10, 100, 0);
        send_pkt("w1", 2, 4);
        chk("w1.nbeats", 256'(outq.size()), 256'(2));
        chk_beat("w1.b1", 1, 32'hFFFFFFFF, 1'b1, 16'd64);
        chk("w1.count", 256'(trunc_count), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
